// File: rtl/mcu_8x8_unpack_if.sv
// Column-in / raster-out stream bundle for mcu_8x8_unpack.
// master drives columns and consumes elements; slave is the block.
interface mcu_8x8_unpack_if #(
  parameter int DW = 8
);
  logic [7:0][DW-1:0] din;
  logic               din_valid;
  logic               din_ready;
  logic [DW-1:0]      dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               dout_last;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  dout,
    input  dout_valid,
    output dout_ready,
    input  dout_last
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output dout,
    output dout_valid,
    input  dout_ready,
    output dout_last
  );
endinterface

// File: rtl/mcu_8x8_unpack.sv
// 8x8 block column-to-raster converter, ping-pong buffered.
// One column in per handshake, one element out per handshake.
module mcu_8x8_unpack #(
  parameter int DW = 8
) (
  input logic              clk,
  input logic              nrst,
  mcu_8x8_unpack_if.slave  s
);

  logic          wr_sel;
  logic          rd_sel;
  logic [2:0]    wr_col;
  logic [5:0]    rd_idx;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic [DW-1:0] mem [2][8][8];
  logic [DW-1:0] dout_q;
  logic          dv_q;
  logic          dl_q;
  logic          din_rdy;
  logic          accept;
  logic          load;
  logic          wr_done;
  logic          rd_done;

  assign din_rdy = ~full[wr_sel];
  assign accept  = s.din_valid & din_rdy;
  assign load    = full[rd_sel] & (~dv_q | s.dout_ready);
  assign wr_done = accept & (wr_col == 3'd7);
  assign rd_done = load & (rd_idx == 6'd63);

  assign s.din_ready  = din_rdy;
  assign s.dout       = dout_q;
  assign s.dout_valid = dv_q;
  assign s.dout_last  = dl_q;

  // Set and clear always target different banks.
  always_comb begin
    full_nxt = full;
    if (wr_done)
      full_nxt[wr_sel] = 1'b1;
    if (rd_done)
      full_nxt[rd_sel] = 1'b0;
  end

  // Storage holds no reset: a bank is only read once marked full.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 8; i++)
        mem[wr_sel][i][wr_col] <= s.din[i];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_sel <= 1'b0;
      wr_col <= 3'd0;
      full   <= 2'b00;
    end else begin
      full <= full_nxt;
      if (accept)
        wr_col <= wr_col + 3'd1;
      if (wr_done)
        wr_sel <= ~wr_sel;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_sel <= 1'b0;
      rd_idx <= 6'd0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      dl_q   <= 1'b0;
    end else begin
      if (load) begin
        dout_q <= mem[rd_sel][rd_idx[5:3]][rd_idx[2:0]];
        dv_q   <= 1'b1;
        dl_q   <= (rd_idx == 6'd63);
        rd_idx <= rd_idx + 6'd1;
      end else if (s.dout_ready) begin
        dv_q <= 1'b0;
        dl_q <= 1'b0;
      end
      if (rd_done)
        rd_sel <= ~rd_sel;
    end
  end

endmodule
